// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences stack operations into push/pop/insert primitives for the downstream stack.
// Define STACK_CTRL_DEPTH_CHECK_EN to add occupancy tracking and underflow/overflow faults.
module stack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [2:0]                    op,
  input  logic [WIDTH-1:0]              imm,
  input  logic [1:0][WIDTH-1:0]         tops,
  output logic                          push,
  output logic                          pop,
  output logic [WIDTH-1:0]              insert,
  output logic [$clog2(DEPTH+1)-1:0]    depth,
  output logic                          fault,
  output logic [1:0]                    fault_code
);

  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_REPL = 3'd3;
  localparam logic [2:0] OP_DUP  = 3'd4;
  localparam logic [2:0] OP_OVER = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {IDLE, SWAP_A, SWAP_B} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic             accept, illegal, underflow, overflow, fault_now, ok;
  logic [1:0]       cause;

  assign op_ready  = (state_q == IDLE) && reset_n;
  assign accept    = op_valid && op_ready;
  assign illegal   = (op == OP_ILL);
  assign fault_now = illegal || underflow || overflow;
  assign ok        = accept && !fault_now;
  assign cause     = illegal ? 2'd3 : (underflow ? 2'd1 : (overflow ? 2'd2 : 2'd0));

`ifdef STACK_CTRL_DEPTH_CHECK_EN
  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    case (op)
      OP_DROP, OP_REPL: underflow = (depth_q == '0);
      OP_DUP: begin
        underflow = (depth_q == '0);
        overflow  = (depth_q == DW'(DEPTH));
      end
      OP_OVER: begin
        underflow = (depth_q < DW'(2));
        overflow  = (depth_q == DW'(DEPTH));
      end
      OP_SWAP: underflow = (depth_q < DW'(2));
      OP_PUSH: overflow  = (depth_q == DW'(DEPTH));
      default: ;
    endcase
  end

  // Occupancy follows the primitives actually driven; push+pop is a net-zero replace.
  always_comb begin
    depth_d = depth_q;
    if (push && !pop)
      depth_d = depth_q + DW'(1);
    else if (pop && !push)
      depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) depth_q <= '0;
    else          depth_q <= depth_d;
  end

  assign depth = depth_q;
`else
  assign underflow = 1'b0;
  assign overflow  = 1'b0;
  assign depth     = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ok && op == OP_SWAP) state_d = SWAP_A;
      SWAP_A:  state_d = SWAP_B;
      SWAP_B:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held so the stack never sees a stray commit.
  always_comb begin
    push   = 1'b0;
    pop    = 1'b0;
    insert = '0;
    if (reset_n) begin
      case (state_q)
        IDLE: if (ok) begin
          case (op)
            OP_PUSH: begin push = 1'b1; insert = imm; end
            OP_DROP: pop = 1'b1;
            OP_REPL: begin push = 1'b1; pop = 1'b1; insert = imm; end
            OP_DUP:  begin push = 1'b1; insert = tops[0]; end
            OP_OVER: begin push = 1'b1; insert = tops[1]; end
            OP_SWAP: pop = 1'b1;
            default: ;
          endcase
        end
        SWAP_A:  begin push = 1'b1; pop = 1'b1; insert = a_q; end
        SWAP_B:  begin push = 1'b1; insert = b_q; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ok && op == OP_SWAP) begin
      a_q <= tops[0];
      b_q <= tops[1];
    end
  end

  // Only the first fault is recorded; later faults leave the code untouched.
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    if (accept && fault_now && !fault_q) begin
      fault_d = 1'b1;
      code_d  = cause;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack model closes the tops loop; expected stack
// primitives are queued by the stimulus and checked by an independent monitor.
module tb_stack_ctrl;
  localparam int W = 32;
  localparam int D = 4;
`ifdef STACK_CTRL_DEPTH_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [2:0]        op = 3'd0;
  logic [W-1:0]      imm = '0;
  logic [1:0][W-1:0] tops;
  logic              push, pop;
  logic [W-1:0]      insert;
  logic [2:0]        depth;
  logic              fault;
  logic [1:0]        fault_code;

  logic [W-1:0] mem [D];
  logic [33:0]  expq [$];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .imm(imm), .tops(tops), .push(push), .pop(pop), .insert(insert),
    .depth(depth), .fault(fault), .fault_code(fault_code)
  );

  // Behavioural stack: registered tops, push+pop replaces the top entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (push && pop) begin
      mem[0] <= insert;
    end else if (push) begin
      for (int i = 1; i < D; i++) mem[i] <= mem[i-1];
      mem[0] <= insert;
    end else if (pop) begin
      for (int i = 0; i < D-1; i++) mem[i] <= mem[i+1];
      mem[D-1] <= '0;
    end
  end
  assign tops[0] = mem[0];
  assign tops[1] = mem[1];

  function automatic logic [31:0] dexp(input int x);
    return EN ? 32'(x) : 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_act(input logic p, input logic pp, input logic [31:0] v);
    expq.push_back({p, pp, v});
  endtask

  // Called and returns at posedge+1; the op commits on the edge in between.
  task automatic do_op(input logic [2:0] o, input logic [31:0] v);
    int n = 0;
    while (!op_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: op_ready stuck at 0, expected 1");
    end
    op_valid = 1'b1; op = o; imm = v;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0; imm = '0;
  endtask

  // Monitor: every stack action the DUT drives must match the next queued expectation.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && (push || pop)) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_action: got push=%0d pop=%0d insert=%0h, expected none", push, pop, insert);
        end else begin
          e = expq.pop_front();
          if ({push, pop} !== e[33:32] || (e[33] && insert !== e[31:0])) begin
            n_fail++;
            $display("FAIL stack_action: got push=%0d pop=%0d insert=%0h, expected push=%0d pop=%0d insert=%0h",
                     push, pop, insert, e[33], e[32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    // Reset state, with a request already pending
    op_valid = 1'b1; op = 3'd1; imm = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", op_ready, 0);
    chk("rst_push", push, 0);
    chk("rst_pop", pop, 0);
    chk("rst_insert", insert, 0);
    op_valid = 1'b0; op = 3'd0; imm = '0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", op_ready, 1);
    chk("post_rst_depth", depth, 0);
    chk("post_rst_fault", fault, 0);
    chk("post_rst_code", fault_code, 0);

    // PUSH, PUSH, DUP
    exp_act(1, 0, 32'h11); do_op(3'd1, 32'h11);
    exp_act(1, 0, 32'h22); do_op(3'd1, 32'h22);
    exp_act(1, 0, 32'h22); do_op(3'd4, 32'h0);
    chk("dup_top0", tops[0], 32'h22);
    chk("dup_top1", tops[1], 32'h22);
    chk("dup_mem2", mem[2], 32'h11);
    chk("dup_depth", depth, dexp(3));
    chk("dup_fault", fault, 0);

    // NOP leaves everything alone
    do_op(3'd0, 32'h77);
    chk("nop_depth", depth, dexp(3));

    // DROP then SWAP
    exp_act(0, 1, 32'h0); do_op(3'd2, 32'h0);
    exp_act(0, 1, 32'h0);
    exp_act(1, 1, 32'h22);
    exp_act(1, 0, 32'h11);
    do_op(3'd6, 32'h0);
    chk("swap_ready_a", op_ready, 0);
    @(posedge clk); #1;
    chk("swap_ready_b", op_ready, 0);
    @(posedge clk); #1;
    chk("swap_ready_done", op_ready, 1);
    chk("swap_top0", tops[0], 32'h11);
    chk("swap_top1", tops[1], 32'h22);
    chk("swap_depth", depth, dexp(2));

    // REPLACE at depth 2, then OVER
    exp_act(1, 1, 32'hAB); do_op(3'd3, 32'hAB);
    chk("repl_top0", tops[0], 32'hAB);
    chk("repl_depth", depth, dexp(2));
    exp_act(1, 0, 32'h22); do_op(3'd5, 32'h0);
    chk("over_top0", tops[0], 32'h22);
    chk("over_top1", tops[1], 32'hAB);
    chk("over_depth", depth, dexp(3));

    // Drain, then DROP on empty, then illegal op
    for (int i = 0; i < 3; i++) begin
      exp_act(0, 1, 32'h0); do_op(3'd2, 32'h0);
    end
    chk("drain_depth", depth, 0);
    if (!EN) exp_act(0, 1, 32'h0);
    do_op(3'd2, 32'h0);
    chk("uflow_fault", fault, EN ? 1 : 0);
    chk("uflow_code", fault_code, EN ? 1 : 0);
    chk("uflow_depth", depth, 0);
    do_op(3'd7, 32'h0);
    chk("ill_after_fault", fault, 1);
    chk("ill_after_code", fault_code, EN ? 1 : 3);

    // Overflow: five pushes into a four-deep stack
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_fault", fault, 0);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4 || !EN) exp_act(1, 0, 32'(k));
      do_op(3'd1, 32'(k));
    end
    chk("oflow_fault", fault, EN ? 1 : 0);
    chk("oflow_code", fault_code, EN ? 2 : 0);
    chk("oflow_depth", depth, dexp(4));
    chk("oflow_top0", tops[0], EN ? 32'h4 : 32'h5);

    // Reset while in SWAP_A
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_act(1, 0, 32'h1); do_op(3'd1, 32'h1);
    exp_act(1, 0, 32'h2); do_op(3'd1, 32'h2);
    exp_act(0, 1, 32'h0); do_op(3'd6, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    chk("midswap_ready", op_ready, 0);
    chk("midswap_push", push, 0);
    chk("midswap_pop", pop, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midswap_idle_ready", op_ready, 1);
    chk("midswap_depth", depth, 0);
    chk("midswap_fault", fault, 0);
    exp_act(1, 0, 32'h5A); do_op(3'd1, 32'h5A);
    chk("post_swap_push_depth", depth, dexp(1));

    // Illegal op on a clean fault register
    do_op(3'd7, 32'h0);
    chk("ill_fault", fault, 1);
    chk("ill_code", fault_code, 3);
    chk("ill_depth", depth, dexp(1));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Operation sequencer that sits directly upstream of the `stack` block and is the only driver of its `push`, `pop` and `insert` inputs. It accepts one stack operation per handshake, translates it into the single-cycle push/pop/replace primitives the stack understands, and sequences SWAP over three cycles. It tracks occupancy so underflow and overflow are caught before they corrupt the stack. It also reads back the top two stack entries to implement DUP, OVER and SWAP.

## Interface
- `WIDTH`, 32, data word width; equals the downstream stack's `WIDTH`.
- `DEPTH`, 8, downstream stack depth; must be 2 or more.

- `clk`  in  1  clock; all state is updated on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `op_valid`  in  1  operation request valid.
- `op_ready`  out  1  an operation can be accepted this cycle.
- `op`  in  3  0 NOP, 1 PUSH, 2 DROP, 3 REPLACE, 4 DUP, 5 OVER, 6 SWAP, 7 illegal.
- `imm`  in  WIDTH  immediate operand for PUSH and REPLACE.
- `tops`  in  [1:0][WIDTH-1:0]  stack tops fed back from the stack; `tops[0]` is the top entry.
- `push`  out  1  to the stack.
- `pop`  out  1  to the stack; `push` and `pop` together replace the top entry.
- `insert`  out  WIDTH  to the stack.
- `depth`  out  $clog2(DEPTH+1)  number of committed valid entries.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  fault cause: 0 none, 1 underflow, 2 overflow, 3 illegal op.

## Operation
- **States:** IDLE, SWAP_A, SWAP_B. `op_ready` = (state == IDLE) && `reset_n`.
- **Accept:** an operation is accepted when `op_valid && op_ready`.
- **Drives in IDLE on accept** (all outputs combinational):
  - PUSH: push=1, insert=`imm`.
  - DROP: pop=1.
  - REPLACE: push=1, pop=1, insert=`imm`.
  - DUP: push=1, insert=`tops[0]`.
  - OVER: push=1, insert=`tops[1]`.
  - SWAP: pop=1; capture a=`tops[0]` and b=`tops[1]`; go to SWAP_A.
  - NOP: no stack action.
- **SWAP_A:** push=1, pop=1, insert=a; go to SWAP_B.
- **SWAP_B:** push=1, insert=b; go to IDLE.
- **Idle outputs:** when no stack action is driven, push=0, pop=0 and insert=0.
- **Depth accounting:**
  - +1 for PUSH, DUP, OVER and the SWAP_B push.
  - −1 for DROP and the SWAP pop.
  - 0 for REPLACE, SWAP_A and NOP.
  - `depth` is registered and reflects the stack contents after each edge.
- **Fault checks** (evaluated at accept, against `depth`):
  - Underflow: DROP, REPLACE or DUP at depth 0; OVER or SWAP at depth below 2.
  - Overflow: PUSH, DUP or OVER at depth == DEPTH.
  - Illegal: op 7.
- **Faulting operation:** still accepted (handshake completes), but push and pop stay 0, depth is unchanged and state stays IDLE.
- **Fault latching:** `fault` is set on the first fault. `fault_code` latches the cause of that first fault and is never overwritten. Only reset clears them.
- **SWAP_A/SWAP_B:** cannot fault, because the checks were passed at accept.

## Timing
- **Reset values:** state IDLE, depth 0, `fault` 0, `fault_code` 0, a and b registers 0. During reset: `op_ready`=0, push=0, pop=0, insert=0.
- **Latency:** zero cycles from accept to stack control. The stack commits on the same edge that completes the handshake.
- **Throughput:** one operation per cycle, except SWAP, which holds `op_ready` low for the two following cycles (3 cycles total).
- **Handshake:** `op_ready` does not depend on `op_valid`. `op`/`imm` are sampled only on the accepting edge.
- **Same-cycle feedback:** `tops` must be valid in the accept cycle. The stack's registered outputs satisfy this with no bypass.
- **Reset mid-SWAP:** the swap is abandoned and the stack contents are undefined; depth returns to 0.
- **Depth limits:** depth never exceeds DEPTH and never wraps below 0.

## Configuration
- **`STACK_CTRL_DEPTH_CHECK_EN` defined:**
  - Depth counter and underflow/overflow checks are present as specified above.
- **`STACK_CTRL_DEPTH_CHECK_EN` not defined:**
  - No depth counter; `depth` is tied to 0.
  - All legal operations execute unconditionally.
  - Only the illegal-op fault (code 3) remains.
  - Handshake and SWAP sequencing are unchanged.

## Test plan
- Reset, then PUSH 0x11, PUSH 0x22, DUP, with `tops` modelled by a real `stack` instance → stack holds 0x22, 0x22, 0x11; depth 3; fault 0.
- From stack 0x22, 0x11, issue SWAP → `op_ready` low for 2 cycles; control sequence pop, replace 0x22, push 0x11; final `tops`=0x11, 0x22; depth 2.
- DROP at depth 0 → accepted, push=pop=0; fault=1, fault_code=1, depth 0. A later op 7 leaves fault_code at 1.
- With DEPTH=4, issue 5 PUSHes of 0x1..0x5 → the 5th push raises fault code 2; depth 4; `tops[0]`=0x4.
- REPLACE 0xAB at depth 2 → push=pop=1 in the same cycle; top becomes 0xAB; depth stays 2.
- Assert `reset_n` low during SWAP_A → `op_ready` and push/pop drop immediately; after release, state IDLE, depth 0, fault 0.
